// File: rtl/cs.sv
// Sliding-window approximate-average filter over the 9 most recent 8-bit
// samples. Y = floor((sum + 9*appr) / 8), where appr is the largest sample
// in the window not above floor(sum / 9).
//
// Stream contract: there is no valid/ready handshake. X is captured on
// every posedge while reset is low. All outputs are purely combinational
// functions of the window registers, so they settle just after posedge and
// hold for the rest of the cycle.
module cs (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] X,
    output logic [9:0] Y,
    output logic [7:0] appr,
    output logic [7:0] avg
);

    localparam int N = 9;

    // Shift window: r_win[0] is the newest sample, r_win[8] the oldest.
    logic [7:0]  r_win [N];

    logic [11:0] w_sum;        // max 9*255 = 2295
    logic [7:0]  w_avg;        // floor(w_sum / 9), max 255
    logic [7:0]  w_appr;       // largest window entry <= w_avg
    logic [11:0] w_appr_x9;    // 9*appr, max 2295
    logic [12:0] w_total;      // sum + 9*appr, max 4590

    // Window shift register: clear on reset, otherwise push X in at the front.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            for (int i = N - 1; i > 0; i--) begin
                r_win[i] <= r_win[i-1];
            end
            r_win[0] <= X;
        end
    end

    // Window sum, accumulated at 12 bits so the worst case cannot wrap.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + {4'b0000, r_win[i]};
        end
    end

    // Exact floor division by the window length; quotient never exceeds 255.
    always_comb begin
        w_avg = 8'(w_sum / 12'd9);
    end

    // Largest entry not above the average; the window minimum always
    // qualifies, so starting from zero gives the correct result.
    always_comb begin
        w_appr = '0;
        for (int i = 0; i < N; i++) begin
            if ((r_win[i] <= w_avg) && (r_win[i] > w_appr)) begin
                w_appr = r_win[i];
            end
        end
    end

    // Output arithmetic: 9*appr as shift-and-add, then divide by 8 by shifting.
    always_comb begin
        w_appr_x9 = {1'b0, w_appr, 3'b000} + {4'b0000, w_appr};
        w_total   = {1'b0, w_sum} + {1'b0, w_appr_x9};
    end

    assign Y    = 10'(w_total >> 3);
    assign appr = w_appr;
    assign avg  = w_avg;

endmodule

// File: tb/tb_cs.sv
// Self-checking bench for the cs approximate-average filter: directed
// windows with hand-computed results, then a random stream with mid-stream
// resets compared against a reference model of the last 9 captures.
module tb_cs;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;
    logic [7:0] appr;
    logic [7:0] avg;

    int checks = 0;
    int errors = 0;

    // Reference window: mdl[0] newest.
    logic [7:0] mdl [9];

    cs dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y),
        .appr  (appr),
        .avg   (avg)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one sample at negedge, let it be captured, return at next negedge.
    task automatic push(input logic [7:0] v);
        X = v;
        @(posedge clk);
        for (int i = 8; i > 0; i--) mdl[i] = mdl[i-1];
        mdl[0] = v;
        @(negedge clk);
    endtask

    // Hold reset for the given number of edges; window and model go to zero.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        for (int i = 0; i < 9; i++) mdl[i] = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [9:0] ey,
                             input logic [7:0] ea, input logic [7:0] ev);
        check({tag, "_Y"},    {6'b0, Y},    {6'b0, ey});
        check({tag, "_appr"}, {8'b0, appr}, {8'b0, ea});
        check({tag, "_avg"},  {8'b0, avg},  {8'b0, ev});
    endtask

    // Reference model evaluated on the bench's own window copy.
    task automatic check_model(input string tag);
        int s, a, p, y;
        s = 0;
        for (int i = 0; i < 9; i++) s += mdl[i];
        a = s / 9;
        p = 0;
        for (int i = 0; i < 9; i++) if (mdl[i] <= a && mdl[i] > p) p = mdl[i];
        y = (s + 9 * p) / 8;
        check_all(tag, 10'(y), 8'(p), 8'(a));
    endtask

    initial begin
        reset = 1'b1;
        X     = '0;
        for (int i = 0; i < 9; i++) mdl[i] = '0;
        @(negedge clk);

        // Reset held for two cycles.
        do_reset(2);
        check_all("reset", 10'd0, 8'd0, 8'd0);

        // First capture after reset: sum=10, avg=1, appr=0, Y=1.
        push(8'd10);
        check_all("first10", 10'd1, 8'd0, 8'd1);

        // Constant window of 10s.
        repeat (8) push(8'd10);
        check_all("const10", 10'd22, 8'd10, 8'd10);

        // Ramp 1..9.
        for (int i = 1; i <= 9; i++) push(8'(i));
        check_all("ramp", 10'd11, 8'd5, 8'd5);

        // Eight zeros then an outlier.
        repeat (8) push(8'd0);
        push(8'd255);
        check_all("outlier", 10'd31, 8'd0, 8'd28);

        // Full-scale window.
        repeat (9) push(8'd255);
        check_all("sat", 10'd573, 8'd255, 8'd255);

        // Mid-stream reset from a full-scale window clears everything.
        do_reset(1);
        check_all("midrst", 10'd0, 8'd0, 8'd0);

        // Random stream with occasional resets, checked every cycle.
        for (int n = 0; n < 2000; n++) begin
            if (n == 700 || n == 1400) begin
                do_reset(1);
                check_model("strm_rst");
            end
            push(8'($urandom_range(0, 255)));
            check_model("strm");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
